// File: rtl/instr_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue: line geometry,
// reset fetch address and the buffered-line entry layout.
package instr_fetch_queue_pkg;

  localparam int LINE_WORDS = 4;
  localparam int WORD_OFF_W = 2;
  localparam logic [31:0] IFQ_PC_RESET = 32'h0040_0000;

  typedef struct packed {
    logic [127:0]           line;
    logic [31:0]            line_pc;
    logic [WORD_OFF_W-1:0]  start_off;
  } ifq_entry_t;

endpackage

// File: rtl/ifq_line_fifo.sv
// Generic DEPTH-entry register FIFO with push/pop/flush; pointers and count
// reset asynchronously, storage is data-only and never reset.
module ifq_line_fifo #(
  parameter int WIDTH = 162,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == ($clog2(DEPTH)+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: requests cache lines, buffers them with their PCs and issues one
// instruction per cycle; redirects flush and restart. IFQ_PERF_EN adds counters.
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          LINE_WIDTH = 128,
  parameter int          DEPTH      = 4,
  parameter logic [31:0] PC_RESET   = IFQ_PC_RESET
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [DATA_WIDTH-1:0] cache_pc,
  output logic                  cache_rd_en,
  output logic                  cache_abort,
  input  logic [LINE_WIDTH-1:0] cache_dout,
  input  logic                  cache_dout_valid,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  input  logic                  disp_rd_en,
  output logic [DATA_WIDTH-1:0] instr_out,
  output logic [DATA_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  output logic                  q_full
`ifdef IFQ_PERF_EN
  ,
  output logic [31:0]           perf_lines,
  output logic [31:0]           perf_full_stall,
  output logic [31:0]           perf_flush
`endif
);

  logic                  rst_q;
  logic [DATA_WIDTH-1:0] fetch_pc;
  logic [WORD_OFF_W-1:0] start_off;
  logic [WORD_OFF_W-1:0] word_ptr;
  logic [WORD_OFF_W-1:0] idx;
  logic                  push;
  logic                  pop_word;
  logic                  pop_line;
  logic                  fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [$bits(ifq_entry_t)-1:0] fifo_rd_data;
  ifq_entry_t            wr_entry;
  ifq_entry_t            head;
  logic                  redir_lsb_unused;

  assign redir_lsb_unused = ^redirect_pc[1:0];

  assign cache_pc    = fetch_pc;
  assign cache_rd_en = ~rst_q & ~q_full & ~redirect_valid;
  assign cache_abort = redirect_valid & ~rst;
  assign push        = cache_rd_en & cache_dout_valid;
  assign pop_word    = disp_rd_en & ~fifo_empty & ~redirect_valid;
  assign pop_line    = pop_word & (idx == WORD_OFF_W'(LINE_WORDS-1));

  assign wr_entry = '{line: cache_dout, line_pc: fetch_pc, start_off: start_off};
  assign head     = ifq_entry_t'(fifo_rd_data);

  ifq_line_fifo #(
    .WIDTH($bits(ifq_entry_t)),
    .DEPTH(DEPTH)
  ) u_line_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop_line),
    .flush   (redirect_valid),
    .wr_data (wr_entry),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .full    (q_full),
    .empty   (fifo_empty)
  );

  // A freshly exposed head line starts at its recorded offset; word_ptr only
  // ever moves forward from there, so the larger of the two is the live word.
  assign idx         = (word_ptr < head.start_off) ? head.start_off : word_ptr;
  assign instr_valid = (fifo_count != '0);
  assign instr_out   = instr_valid ? DATA_WIDTH'(head.line[{idx, 5'd0} +: 32]) : '0;
  assign instr_pc    = instr_valid ?
                       DATA_WIDTH'(head.line_pc) + {{(DATA_WIDTH-WORD_OFF_W-2){1'b0}}, idx, 2'b00} : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_q     <= 1'b1;
      fetch_pc  <= DATA_WIDTH'(PC_RESET);
      start_off <= '0;
      word_ptr  <= '0;
    end else begin
      rst_q <= 1'b0;
      if (redirect_valid) begin
        fetch_pc  <= {redirect_pc[DATA_WIDTH-1:4], 4'h0};
        start_off <= redirect_pc[3:2];
        word_ptr  <= '0;
      end else begin
        if (push) begin
          fetch_pc  <= fetch_pc + DATA_WIDTH'(16);
          start_off <= '0;
        end
        if (pop_word) word_ptr <= pop_line ? '0 : idx + 1'b1;
      end
    end
  end

`ifdef IFQ_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_lines      <= '0;
      perf_full_stall <= '0;
      perf_flush      <= '0;
    end else begin
      if (push)           perf_lines      <= sat_inc(perf_lines);
      if (q_full)         perf_full_stall <= sat_inc(perf_full_stall);
      if (redirect_valid) perf_flush      <= sat_inc(perf_flush);
    end
  end
`endif

endmodule
